// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and counter sizing.
package alu_pkg;

  localparam logic [3:0] OP_NOT  = 4'h0;
  localparam logic [3:0] OP_XOR  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_RR   = 4'h6;
  localparam logic [3:0] OP_RL   = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_INC  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_DIV  = 4'hB;
  localparam logic [3:0] OP_CLRF = 4'hC;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StFin
  } state_e;

  // The counter must be able to hold the value w itself.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative datapath: shift-add multiply and restoring divide, one bit per step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              div_mode,
  input  logic [DWIDTH-1:0] opa,
  input  logic [DWIDTH-1:0] opb,
  input  logic              step,
  output logic [DWIDTH-1:0] res_lo,
  output logic [DWIDTH-1:0] res_hi,
  output logic              last,
  output logic              is_div
);

  localparam int unsigned CntW = cnt_width(DWIDTH);

  logic [DWIDTH-1:0] lo_q, hi_q, opb_q;
  logic              div_q;
  logic [CntW-1:0]   cnt_q;

  logic [DWIDTH:0]   mul_sum;
  logic [DWIDTH:0]   div_shift;
  logic [DWIDTH-1:0] div_diff;
  logic              div_ge;

  // res_lo/res_hi are the register values after the current step, so the
  // top can capture the final result on the same edge as the last step.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {hi_q, lo_q[DWIDTH-1]};
    div_diff  = div_shift[DWIDTH-1:0] - opb_q;
    div_ge    = (div_shift >= {1'b0, opb_q});
    if (div_q) begin
      res_hi = div_ge ? div_diff : div_shift[DWIDTH-1:0];
      res_lo = {lo_q[DWIDTH-2:0], div_ge};
    end else begin
      res_hi = mul_sum[DWIDTH:1];
      res_lo = {mul_sum[0], lo_q[DWIDTH-1:1]};
    end
  end

  assign last   = (cnt_q == CntW'(DWIDTH - 1));
  assign is_div = div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      hi_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      lo_q  <= opa;
      hi_q  <= '0;
      opb_q <= opb;
      div_q <= div_mode;
      cnt_q <= '0;
    end else if (step) begin
      lo_q  <= res_lo;
      hi_q  <= res_hi;
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered results, persistent C/B/Z flags, iterative MUL/DIV
// behind a start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter bit          MUL_EN = 1'b1,
  parameter bit          DIV_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        in_instr,
  input  logic [DWIDTH-1:0] in_a,
  input  logic [DWIDTH-1:0] in_b,
  output logic [DWIDTH-1:0] out,
  output logic [DWIDTH-1:0] out_hi,
  output logic              busy,
  output logic              done,
  output logic              c_flag,
  output logic              b_flag,
  output logic              z_flag,
  output logic              div0
);

  state_e            state_q;
  logic [DWIDTH-1:0] out_q, hi_q;
  logic              busy_q, done_q, c_q, b_q, z_q, div0_q;

  logic [DWIDTH:0]   add_w, sub_w, inc_w, dec_w;
  logic [DWIDTH-1:0] sc_out, sc_hi;
  logic              sc_c, sc_b, sc_z, sc_div0;
  logic              go_iter, accept;

  logic [DWIDTH-1:0] md_lo, md_hi;
  logic              md_last, md_div, md_z;

  assign add_w = {1'b0, in_a} + {1'b0, in_b} + {{DWIDTH{1'b0}}, c_q};
  assign sub_w = {1'b0, in_a} - {1'b0, in_b} - {{DWIDTH{1'b0}}, b_q};
  assign inc_w = {1'b0, in_a} + {{DWIDTH{1'b0}}, 1'b1};
  assign dec_w = {1'b0, in_a} - {{DWIDTH{1'b0}}, 1'b1};

  // Only enabled MUL, and DIV with a non-zero divisor, go through the iterative path.
  assign go_iter = (MUL_EN && (in_instr == OP_MUL)) ||
                   (DIV_EN && (in_instr == OP_DIV) && (in_b != '0));
  assign accept  = start && (state_q != StExec);

  always_comb begin
    sc_out  = in_b;
    sc_hi   = '0;
    sc_c    = c_q;
    sc_b    = b_q;
    sc_div0 = 1'b0;
    case (in_instr)
      OP_NOT: sc_out = ~in_a;
      OP_XOR: sc_out = in_a ^ in_b;
      OP_OR:  sc_out = in_a | in_b;
      OP_AND: sc_out = in_a & in_b;
      OP_SUB: {sc_b, sc_out} = sub_w;
      OP_ADD: {sc_c, sc_out} = add_w;
      OP_RR:  sc_out = {1'b0, in_a[DWIDTH-1:1]};
      OP_RL:  sc_out = {in_a[DWIDTH-2:0], 1'b0};
      OP_DEC: {sc_b, sc_out} = dec_w;
      OP_INC: {sc_c, sc_out} = inc_w;
      OP_DIV: begin
        if (DIV_EN && (in_b == '0)) begin
          sc_out  = '1;
          sc_hi   = in_a;
          sc_div0 = 1'b1;
        end
      end
      OP_CLRF: begin
        sc_c = 1'b0;
        sc_b = 1'b0;
      end
      default: ;
    endcase
    sc_z = (sc_out == '0);
  end

  assign md_z = (md_lo == '0) && (md_div || (md_hi == '0));

  alu_muldiv #(
    .DWIDTH(DWIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && go_iter),
    .div_mode(in_instr == OP_DIV),
    .opa     (in_a),
    .opb     (in_b),
    .step    (state_q == StExec),
    .res_lo  (md_lo),
    .res_hi  (md_hi),
    .last    (md_last),
    .is_div  (md_div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      out_q   <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= 1'b0;
      b_q     <= 1'b0;
      z_q     <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StFin: begin
          state_q <= StIdle;
          if (start) begin
            if (go_iter) begin
              state_q <= StExec;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StFin;
              done_q  <= 1'b1;
              out_q   <= sc_out;
              hi_q    <= sc_hi;
              c_q     <= sc_c;
              b_q     <= sc_b;
              z_q     <= sc_z;
              div0_q  <= sc_div0;
            end
          end
        end
        StExec: begin
          if (md_last) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            out_q   <= md_lo;
            hi_q    <= md_hi;
            z_q     <= md_z;
            div0_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out    = out_q;
  assign out_hi = hi_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign c_flag = c_q;
  assign b_flag = b_q;
  assign z_flag = z_q;
  assign div0   = div0_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed scenarios plus random ops against an
// arithmetic reference model.
module tb_alu_mc;

  logic       clk, rst_n, start;
  logic [3:0] instr;
  logic [7:0] a, b;
  logic [7:0] out, out_hi;
  logic       busy, done, c_flag, b_flag, z_flag, div0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state and expectations
  int m_c, m_b, m_div0;
  int e_out, e_hi, e_lat, e_z;

  alu_mc #(
    .DWIDTH(8),
    .MUL_EN(1'b1),
    .DIV_EN(1'b1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_instr(instr),
    .in_a    (a),
    .in_b    (b),
    .out     (out),
    .out_hi  (out_hi),
    .busy    (busy),
    .done    (done),
    .c_flag  (c_flag),
    .b_flag  (b_flag),
    .z_flag  (z_flag),
    .div0    (div0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int op, input int x, input int y);
    int s;
    e_hi   = 0;
    e_lat  = 1;
    m_div0 = 0;
    case (op)
      0: e_out = (~x) & 255;
      1: e_out = x ^ y;
      2: e_out = x | y;
      3: e_out = x & y;
      4: begin s = x - y - m_b; m_b = (s < 0); e_out = s & 255; end
      5: begin s = x + y + m_c; m_c = (s > 255); e_out = s & 255; end
      6: e_out = x >> 1;
      7: e_out = (x << 1) & 255;
      8: begin s = x - 1; m_b = (s < 0); e_out = s & 255; end
      9: begin s = x + 1; m_c = (s > 255); e_out = s & 255; end
      10: begin s = x * y; e_out = s & 255; e_hi = s >> 8; e_lat = 9; end
      11: begin
        if (y == 0) begin e_out = 255; e_hi = x; m_div0 = 1; end
        else begin e_out = x / y; e_hi = x % y; e_lat = 9; end
      end
      12: begin m_c = 0; m_b = 0; e_out = y; end
      default: e_out = y;
    endcase
    e_z = (e_out == 0) && (op != 10 || e_hi == 0);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out"}, out, e_out);
    check({tag, ".hi"}, out_hi, e_hi);
    check({tag, ".c"}, c_flag, m_c);
    check({tag, ".b"}, b_flag, m_b);
    check({tag, ".z"}, z_flag, e_z);
    check({tag, ".div0"}, div0, m_div0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"}, out, 0);
    check({tag, ".hi"}, out_hi, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".c"}, c_flag, 0);
    check({tag, ".b"}, b_flag, 0);
    check({tag, ".z"}, z_flag, 0);
    check({tag, ".div0"}, div0, 0);
  endtask

  task automatic issue(input int op, input int x, input int y);
    @(negedge clk);
    instr = 4'(op);
    a     = 8'(x);
    b     = 8'(y);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // cyc0 = cycles already elapsed since the start edge
  task automatic await_done(input string tag, input int cyc0);
    int cyc = cyc0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".lat"}, cyc, e_lat);
    check_outputs(tag);
    check({tag, ".busy_end"}, busy, 0);
    @(negedge clk);
    check({tag, ".pulse"}, done, 0);
  endtask

  task automatic run_op(input string tag, input int op, input int x, input int y);
    model(op, x, y);
    issue(op, x, y);
    check({tag, ".busy"}, busy, (e_lat > 1));
    await_done(tag, 1);
  endtask

  initial begin
    int seen;
    start  = 1'b0;
    instr  = '0;
    a      = '0;
    b      = '0;
    rst_n  = 1'b1;
    m_c    = 0;
    m_b    = 0;
    m_div0 = 0;
    #2 rst_n = 1'b0;
    #2 check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add1", 5, 'hF0, 'h20);
    run_op("add2", 5, 'h01, 'h01);
    run_op("mul_ff", 10, 'hFF, 'hFF);
    run_op("mul_0", 10, 'h00, 'h37);
    run_op("div", 11, 'hC8, 'h07);
    run_op("div_by0", 11, 'hC8, 'h00);
    run_op("add_clr_div0", 5, 'h11, 'h22);
    run_op("sub", 4, 'h00, 'h01);
    run_op("dec", 8, 'h01, 'h00);
    run_op("add_carry", 5, 'hFF, 'h01);
    run_op("clrf", 12, 'h33, 'h44);

    // START pulses with ADD while MUL is busy must be ignored
    model(10, 'hFF, 'h02);
    issue(10, 'hFF, 'h02);
    check("ign.busy", busy, 1);
    repeat (2) @(negedge clk);
    instr = 4'h5;
    a     = 8'h01;
    b     = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await_done("ign", 6);

    // START held through FIN: second op accepted with no idle cycle
    model(5, 'h10, 'h20);
    @(negedge clk);
    instr = 4'h5;
    a     = 8'h10;
    b     = 8'h20;
    start = 1'b1;
    @(negedge clk);
    check("b2b1.done", done, 1);
    check_outputs("b2b1");
    model(1, 'h5A, 'h0F);
    instr = 4'h1;
    a     = 8'h5A;
    b     = 8'h0F;
    @(negedge clk);
    start = 1'b0;
    check("b2b2.done", done, 1);
    check_outputs("b2b2");
    @(negedge clk);
    check("b2b.pulse", done, 0);

    // Reset during DIV: everything clears immediately and no DONE follows
    issue(11, 'hC8, 'h07);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    m_c    = 0;
    m_b    = 0;
    m_div0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    check("midrst.nodone", seen, 0);
    run_op("post_rst_add", 5, 'h02, 'h03);

    for (int i = 0; i < 150; i++) begin
      int op, x, y;
      op = $urandom_range(0, 15);
      x  = $urandom_range(0, 255);
      y  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run_op($sformatf("rnd%0d_op%0d", i, op), op, x, y);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle datapath ALU. It registers its results and keeps internal carry, borrow and zero flags across instructions, so chained ADD/SUB carry and borrow without external wiring. It adds iterative MUL and DIV with a START/BUSY/DONE handshake. It sits between the register file and the accumulator in the CPU datapath; the control unit drives START once per ALU instruction.

Parameters:
DWIDTH, 8, operand/result width (>=4)
MUL_EN, 1, 0 = MUL opcode behaves as pass-through
DIV_EN, 1, 0 = DIV opcode behaves as pass-through

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
START  in  1  request; sampled only when not BUSY
IN_INSTR  in  4  opcode, latched with START
IN_A  in  DWIDTH  operand A, latched with START
IN_B  in  DWIDTH  operand B, latched with START
OUT  out  DWIDTH  result (low half / quotient)
OUT_HI  out  DWIDTH  MUL high half / DIV remainder; 0 for all other ops
BUSY  out  1  multi-cycle op in progress
DONE  out  1  one-cycle pulse: OUT/OUT_HI/flags just updated
C_FLAG  out  1  carry flag
B_FLAG  out  1  borrow flag
Z_FLAG  out  1  zero flag
DIV0  out  1  last DIV had divisor 0; cleared by next completion

Behaviour:
- Reset: async on nRST low. All outputs go to 0, FSM goes to IDLE, operand and iteration registers are cleared. Reset mid-operation abandons the op, and no DONE follows.
- FSM states: IDLE, EXEC, FIN.
  - IDLE + START with a single-cycle op: result and flags registered on that edge; go to FIN.
  - IDLE + START with MUL/DIV (enabled, divisor != 0): latch operands; go to EXEC.
  - EXEC runs DWIDTH cycles with BUSY=1, one bit per cycle (shift-add MUL, restoring DIV). It then registers the result and goes to FIN.
  - FIN: DONE=1 for one cycle. START is accepted in FIN exactly as in IDLE, which allows back-to-back ops. Without START, FIN goes to IDLE.
- Latency: single-cycle ops show DONE 1 cycle after the START edge. MUL/DIV show DONE DWIDTH+1 cycles after the START edge.
- START is ignored while BUSY. Outputs hold their last value until the next completion.
- Opcodes and their results:
  - 0 NOT: ~A
  - 1 XOR: A^B
  - 2 OR: A|B
  - 3 AND: A&B
  - 4 SUB: {B,OUT} = A−B−B_FLAG
  - 5 ADD: {C,OUT} = A+B+C_FLAG
  - 6 RR: zero-fill logical shift right by 1
  - 7 RL: zero-fill logical shift left by 1
  - 8 DEC: A−1 always, regardless of B_FLAG; borrow out goes to B_FLAG
  - 9 INC: A+1 always, regardless of C_FLAG; carry out goes to C_FLAG
  - A MUL: {OUT_HI,OUT} = A*B, unsigned
  - B DIV: OUT = A/B, OUT_HI = A%B, unsigned
  - C CLRF: C_FLAG=B_FLAG=0; OUT = IN_B
  - D–F: OUT = IN_B (LD/ST/NOP pass-through)
- Flag updates happen only at completion:
  - C_FLAG changes only on ADD/INC.
  - B_FLAG changes only on SUB/DEC.
  - Z_FLAG = (OUT==0), and for MUL also requires OUT_HI==0. It updates on every op.
- DIV by zero completes in 1 cycle (no EXEC): OUT = all-ones, OUT_HI = A, DIV0=1, Z_FLAG=0.
- Disabled MUL/DIV (MUL_EN/DIV_EN = 0) behave as opcode D: 1-cycle pass-through.
- Width rules: all arithmetic is unsigned modulo 2^DWIDTH. The MUL product is 2*DWIDTH bits. The iteration counter is clog2(DWIDTH+1) bits.

Decomposition:
- Package alu_pkg holds: the 4-bit opcode constants (OP_NOT..OP_DIV, OP_CLRF), the FSM state typedef, and the iteration-counter width function.
- One sub-module, alu_muldiv, holds the iterative shift-add/restoring-divide datapath: operand/partial registers, counter, a step-enable input and a done output.
- alu_mc top holds: the FSM, the single-cycle ops, the flag registers and the output registers.

Test Plan:
- ADD 0xF0+0x20 (C=0) → OUT=0x10, C=1, DONE 1 cycle after START. Then ADD 0x01+0x01 → OUT=0x03, C=0.
- MUL 0xFF*0xFF → BUSY high 8 cycles, DONE at cycle 9, OUT=0x01, OUT_HI=0xFE, Z=0. Then MUL 0x00*0x37 → OUT=0, OUT_HI=0, Z=1.
- DIV 0xC8/0x07 → OUT=0x1C, OUT_HI=0x04 after 9 cycles. DIV 0xC8/0x00 → 1-cycle, OUT=0xFF, OUT_HI=0xC8, DIV0=1. Next ADD clears DIV0.
- SUB 0x00−0x01 (B=0) → OUT=0xFF, B=1. DEC 0x01 with B=1 → OUT=0x00, Z=1, B=0. CLRF → C=B=0.
- START pulses with ADD during MUL BUSY → ignored, MUL result intact. START held high in the FIN cycle → next op accepted with no idle cycle.
- nRST low during cycle 4 of DIV → all outputs 0 immediately, no DONE. After release, ADD 0x02+0x03 → OUT=0x05, DONE 1 cycle later.
